// File: rtl/toy_imem_responder.sv
// Instruction-memory responder: request/ack slave with pipelined array reads, in-order response FIFO,
// byte-masked loader port and flush. Optional address range checking via TOY_IMEM_RANGE_CHK_EN.
module toy_imem_responder #(
   parameter int unsigned             ADDR_WIDTH = 32,
   parameter int unsigned             INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned             MEM_WORDS  = 16384,
   parameter int unsigned             RD_LAT     = 2,
   parameter int unsigned             RSP_DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_vld,
   output logic                      req_rdy,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   output logic                      ack_vld,
   input  logic                      ack_rdy,
   output logic [INST_WIDTH-1:0]     ack_data,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [INST_WIDTH-1:0]     wr_data,
   input  logic [INST_WIDTH/8-1:0]   wr_strb
`ifdef TOY_IMEM_RANGE_CHK_EN
   ,
   output logic                      ack_err
`endif
);

   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
   localparam int unsigned STRB_W = INST_WIDTH / 8;
   localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
   localparam int unsigned HI_W   = ADDR_WIDTH - IDX_W - 2;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1'b1);
      end
   endfunction

   logic [ADDR_WIDTH-1:0] rd_off_s, wr_off_s;
   logic [IDX_W-1:0]      rd_idx_s, wr_idx_s;
   logic                  rd_ok_s, wr_ok_s;
   logic                  acc_s;
   logic                  req_rdy_q, req_rdy_d;
   logic [CNT_W-1:0]      out_q, out_d;
   logic [INST_WIDTH-1:0] rd_data_s;
   logic [INST_WIDTH-1:0] wr_word_s;
   logic [INST_WIDTH-1:0] mem_q [MEM_WORDS];

   logic                  push_s;
   logic [INST_WIDTH-1:0] push_data_s;
   logic                  push_err_s;

   logic [INST_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
   logic [INST_WIDTH-1:0] fifo_data_d [RSP_DEPTH];
   logic [RSP_DEPTH-1:0]  fifo_err_q, fifo_err_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ack_vld_s, pop_s, head_err_s;
   logic                  unused_s;

   // Address decode: word index relative to BASE_ADDR, plus range qualification.
   always_comb begin
      rd_off_s = req_addr - BASE_ADDR;
      wr_off_s = wr_addr - BASE_ADDR;
      rd_idx_s = rd_off_s[IDX_W+1:2];
      wr_idx_s = wr_off_s[IDX_W+1:2];
`ifdef TOY_IMEM_RANGE_CHK_EN
      rd_ok_s  = (rd_off_s[ADDR_WIDTH-1:IDX_W+2] == {HI_W{1'b0}});
      wr_ok_s  = (wr_off_s[ADDR_WIDTH-1:IDX_W+2] == {HI_W{1'b0}});
`else
      rd_ok_s  = 1'b1;
      wr_ok_s  = 1'b1;
`endif
   end

`ifdef TOY_IMEM_RANGE_CHK_EN
   assign unused_s = ^{rd_off_s[1:0], wr_off_s[1:0]};
`else
   assign unused_s = ^{rd_off_s[1:0], wr_off_s[1:0], rd_off_s[ADDR_WIDTH-1:IDX_W+2],
                       wr_off_s[ADDR_WIDTH-1:IDX_W+2], head_err_s};
`endif

   // Array read (old contents until the write edge, giving read-first) and byte-merged write word.
   always_comb begin
      rd_data_s = rd_ok_s ? mem_q[rd_idx_s] : {INST_WIDTH{1'b0}};
      wr_word_s = mem_q[wr_idx_s];
      for (int b = 0; b < STRB_W; b++) begin
         if (wr_strb[b]) begin
            wr_word_s[8*b +: 8] = wr_data[8*b +: 8];
         end else begin
            wr_word_s[8*b +: 8] = mem_q[wr_idx_s][8*b +: 8];
         end
      end
   end

   // Loader write port; array contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && wr_ok_s) begin
         mem_q[wr_idx_s] <= wr_word_s;
      end
   end

   assign acc_s = req_vld && req_rdy;

   // Read pipeline: the array read happens in the accept cycle, RD_LAT-1 register stages follow.
   generate
      if (RD_LAT == 1) begin : g_lat1
         always_comb begin
            push_s      = acc_s;
            push_data_s = rd_data_s;
            push_err_s  = ~rd_ok_s;
         end
      end else begin : g_pipe
         localparam int unsigned NS = RD_LAT - 1;
         logic [NS-1:0]         vld_q, vld_d, err_q, err_d;
         logic [INST_WIDTH-1:0] data_q [NS];
         logic [INST_WIDTH-1:0] data_d [NS];

         // Stage shift; flush kills everything already in flight but keeps this cycle's accept.
         always_comb begin
            vld_d     = {NS{1'b0}};
            err_d     = {NS{1'b0}};
            vld_d[0]  = acc_s;
            err_d[0]  = ~rd_ok_s;
            data_d[0] = rd_data_s;
            for (int k = 1; k < NS; k++) begin
               vld_d[k]  = vld_q[k-1] && !flush;
               err_d[k]  = err_q[k-1];
               data_d[k] = data_q[k-1];
            end
            push_s      = vld_q[NS-1] && !flush;
            push_data_s = data_q[NS-1];
            push_err_s  = err_q[NS-1];
         end

         // Pipeline stage registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= {NS{1'b0}};
               err_q <= {NS{1'b0}};
               for (int k = 0; k < NS; k++) data_q[k] <= {INST_WIDTH{1'b0}};
            end else begin
               vld_q <= vld_d;
               err_q <= err_d;
               for (int k = 0; k < NS; k++) data_q[k] <= data_d[k];
            end
         end
      end
   endgenerate

   assign ack_vld_s  = (cnt_q != {CNT_W{1'b0}}) && !flush;
   assign pop_s      = ack_vld_s && ack_rdy;
   assign head_err_s = fifo_err_q[rd_ptr_q];

   // Response FIFO and credit counter next-state; a flush empties the FIFO before this cycle's push.
   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_err_d  = fifo_err_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = flush ? rd_ptr_q : wr_ptr_q;
      cnt_d       = flush ? {CNT_W{1'b0}} : cnt_q;
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         cnt_d    = cnt_d - CNT_W'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
         fifo_data_d[wr_ptr_d] = push_data_s;
         fifo_err_d[wr_ptr_d]  = push_err_s;
         wr_ptr_d              = ptr_inc(wr_ptr_d);
         cnt_d                 = cnt_d + CNT_W'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_d;
      end

      if (flush) begin
         out_d = acc_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
      end else begin
         out_d = out_q + (acc_s ? CNT_W'(1'b1) : {CNT_W{1'b0}})
                       - (pop_s ? CNT_W'(1'b1) : {CNT_W{1'b0}});
      end
      req_rdy_d = (out_d < CNT_W'(RSP_DEPTH));
   end

   // FIFO, pointer and credit registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RSP_DEPTH; i++) fifo_data_q[i] <= {INST_WIDTH{1'b0}};
         fifo_err_q <= {RSP_DEPTH{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         out_q      <= {CNT_W{1'b0}};
         req_rdy_q  <= 1'b0;
      end else begin
         fifo_data_q <= fifo_data_d;
         fifo_err_q  <= fifo_err_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         req_rdy_q   <= req_rdy_d;
      end
   end

   assign req_rdy  = req_rdy_q || flush;
   assign ack_vld  = ack_vld_s;
   assign ack_data = fifo_data_q[rd_ptr_q];
`ifdef TOY_IMEM_RANGE_CHK_EN
   assign ack_err  = ack_vld_s && head_err_s;
`endif

endmodule

// File: tb/tb_toy_imem_responder.sv
// Directed self-checking bench for toy_imem_responder (defaults: RD_LAT=2, RSP_DEPTH=4, MEM_WORDS=16384).
module tb_toy_imem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n, req_vld, ack_rdy, flush, wr_en;
   logic [31:0] req_addr, wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic        req_rdy, ack_vld;
   logic [31:0] ack_data;
`ifdef TOY_IMEM_RANGE_CHK_EN
   logic        ack_err;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   toy_imem_responder dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
      .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_data(ack_data), .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
`ifdef TOY_IMEM_RANGE_CHK_EN
      , .ack_err(ack_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc();
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_vld = 1'b0; ack_rdy = 1'b0; flush = 1'b0; wr_en = 1'b0;
      req_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; wr_strb = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL rst_ack_vld got=%0b exp=0", ack_vld); else n_pass++;
      n_chk++; if (ack_data !== 32'h0) $display("FAIL rst_ack_data got=%h exp=0", ack_data); else n_pass++;
      n_chk++; if (req_rdy !== 1'b0) $display("FAIL rst_req_rdy got=%0b exp=0", req_rdy); else n_pass++;
`ifdef TOY_IMEM_RANGE_CHK_EN
      n_chk++; if (ack_err !== 1'b0) $display("FAIL rst_ack_err got=%0b exp=0", ack_err); else n_pass++;
`endif
      rst_n = 1'b1;
      cyc();
      n_chk++; if (req_rdy !== 1'b1) $display("FAIL rst_rel_req_rdy got=%0b exp=1", req_rdy); else n_pass++;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL rst_rel_ack_vld got=%0b exp=0", ack_vld); else n_pass++;
   endtask

   task automatic test_basic();
      do_write(BASE, 32'h0000_0013, 4'hF);
      do_write(BASE + 32'h4, 32'h0010_0093, 4'hF);
      cyc(); ack_rdy = 1'b1; req_vld = 1'b1; req_addr = BASE; #3;
      n_chk++; if (req_rdy !== 1'b1) $display("FAIL basic_rdy got=%0b exp=1", req_rdy); else n_pass++;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL basic_t0_vld got=%0b exp=0", ack_vld); else n_pass++;
      cyc(); req_addr = BASE + 32'h4; #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL basic_t1_vld got=%0b exp=0", ack_vld); else n_pass++;
      cyc(); req_vld = 1'b0; #3;
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== 32'h0000_0013)
         $display("FAIL basic_t2 vld=%0b data=%h exp vld=1 data=00000013", ack_vld, ack_data); else n_pass++;
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== 32'h0010_0093)
         $display("FAIL basic_t3 vld=%0b data=%h exp vld=1 data=00100093", ack_vld, ack_data); else n_pass++;
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL basic_t4_vld got=%0b exp=0", ack_vld); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) do_write(BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      for (int c = 0; c < 11; c++) begin
         cyc(); ack_rdy = 1'b1; req_vld = (c < 8); req_addr = BASE + 32'(4 * c); #3;
         if (c < 8) begin
            n_chk++; if (req_rdy !== 1'b1) $display("FAIL stream_rdy c=%0d got=%0b exp=1", c, req_rdy); else n_pass++;
         end
         if (c >= 2 && c < 10) begin
            exp = 32'hA000_0000 + 32'(c - 2);
            n_chk++; if (ack_vld !== 1'b1 || ack_data !== exp)
               $display("FAIL stream_ack c=%0d vld=%0b data=%h exp vld=1 data=%h", c, ack_vld, ack_data, exp);
            else n_pass++;
         end else begin
            n_chk++; if (ack_vld !== 1'b0) $display("FAIL stream_idle c=%0d vld=%0b exp=0", c, ack_vld); else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      logic [31:0] exp;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         cyc(); ack_rdy = 1'b0; req_vld = 1'b1; req_addr = BASE + 32'(4 * acc); #3;
         n_chk++; if (req_rdy !== (c < 4)) $display("FAIL bp_rdy c=%0d got=%0b exp=%0b", c, req_rdy, (c < 4)); else n_pass++;
         if (c >= 2) begin
            n_chk++; if (ack_vld !== 1'b1 || ack_data !== 32'hA000_0000)
               $display("FAIL bp_hold c=%0d vld=%0b data=%h exp vld=1 data=a0000000", c, ack_vld, ack_data);
            else n_pass++;
         end
         if (req_vld && req_rdy) acc++;
      end
      n_chk++; if (acc !== 4) $display("FAIL bp_accepts got=%0d exp=4", acc); else n_pass++;
      cyc(); ack_rdy = 1'b1; req_addr = BASE + 32'(4 * acc); #3;
      n_chk++; if (req_rdy !== 1'b0) $display("FAIL bp_pop_rdy got=%0b exp=0", req_rdy); else n_pass++;
      if (req_vld && req_rdy) acc++;
      cyc(); ack_rdy = 1'b0; req_addr = BASE + 32'(4 * acc); #3;
      n_chk++; if (req_rdy !== 1'b1) $display("FAIL bp_after_pop_rdy got=%0b exp=1", req_rdy); else n_pass++;
      n_chk++; if (ack_data !== 32'hA000_0001) $display("FAIL bp_new_head got=%h exp=a0000001", ack_data); else n_pass++;
      if (req_vld && req_rdy) acc++;
      for (int c = 0; c < 3; c++) begin
         cyc(); req_addr = BASE + 32'(4 * acc); #3;
         n_chk++; if (req_rdy !== 1'b0) $display("FAIL bp_refull c=%0d got=%0b exp=0", c, req_rdy); else n_pass++;
         if (req_vld && req_rdy) acc++;
      end
      n_chk++; if (acc !== 5) $display("FAIL bp_total_accepts got=%0d exp=5", acc); else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         cyc(); req_vld = 1'b0; ack_rdy = 1'b1; #3;
         exp = 32'hA000_0000 + 32'(k);
         n_chk++; if (ack_vld !== 1'b1 || ack_data !== exp)
            $display("FAIL bp_drain k=%0d vld=%0b data=%h exp vld=1 data=%h", k, ack_vld, ack_data, exp);
         else n_pass++;
      end
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL bp_empty got=%0b exp=0", ack_vld); else n_pass++;
   endtask

   task automatic test_flush();
      do_write(BASE + 32'h100, 32'hCAFE_0100, 4'hF);
      for (int i = 0; i < 3; i++) begin
         cyc(); ack_rdy = 1'b0; req_vld = 1'b1; req_addr = BASE + 32'(4 * i); #3;
         n_chk++; if (req_rdy !== 1'b1) $display("FAIL fl_pre_rdy i=%0d got=%0b exp=1", i, req_rdy); else n_pass++;
      end
      cyc(); flush = 1'b1; ack_rdy = 1'b1; req_addr = BASE + 32'h100; #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL fl_cycle_vld got=%0b exp=0", ack_vld); else n_pass++;
      n_chk++; if (req_rdy !== 1'b1) $display("FAIL fl_cycle_rdy got=%0b exp=1", req_rdy); else n_pass++;
      cyc(); flush = 1'b0; req_vld = 1'b0; #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL fl_t1_vld got=%0b exp=0", ack_vld); else n_pass++;
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== 32'hCAFE_0100)
         $display("FAIL fl_t2 vld=%0b data=%h exp vld=1 data=cafe0100", ack_vld, ack_data); else n_pass++;
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL fl_t3_vld got=%0b exp=0", ack_vld); else n_pass++;
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b0) $display("FAIL fl_t4_vld got=%0b exp=0", ack_vld); else n_pass++;
   endtask

   task automatic test_read_first();
      do_write(BASE + 32'h8, 32'h1111_2222, 4'hF);
      cyc(); ack_rdy = 1'b1; req_vld = 1'b1; req_addr = BASE + 32'h8;
      wr_en = 1'b1; wr_addr = BASE + 32'h8; wr_data = 32'hDEAD_BEEF; wr_strb = 4'b0011; #3;
      cyc(); wr_en = 1'b0; #3;
      cyc(); req_vld = 1'b0; #3;
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== 32'h1111_2222)
         $display("FAIL rf_old vld=%0b data=%h exp vld=1 data=11112222", ack_vld, ack_data); else n_pass++;
      cyc(); #3;
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== 32'h1111_BEEF)
         $display("FAIL rf_new vld=%0b data=%h exp vld=1 data=1111beef", ack_vld, ack_data); else n_pass++;
      cyc(); #3;
   endtask

   task automatic test_range();
      logic [31:0] exp;
      do_write(BASE + 32'hFFFC, 32'h5A5A_0FFF, 4'hF);
      cyc(); ack_rdy = 1'b1; req_vld = 1'b1; req_addr = 32'h7FFF_FFFC; #3;
      cyc(); req_vld = 1'b0; #3;
      cyc(); #3;
`ifdef TOY_IMEM_RANGE_CHK_EN
      exp = 32'h0;
      n_chk++; if (ack_err !== 1'b1) $display("FAIL rng_oor_err got=%0b exp=1", ack_err); else n_pass++;
`else
      exp = 32'h5A5A_0FFF;
`endif
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== exp)
         $display("FAIL rng_oor_read vld=%0b data=%h exp vld=1 data=%h", ack_vld, ack_data, exp); else n_pass++;
      do_write(32'h7FFF_FFFC, 32'h1234_5678, 4'hF);
      cyc(); req_vld = 1'b1; req_addr = BASE + 32'hFFFC; #3;
      cyc(); req_vld = 1'b0; #3;
      cyc(); #3;
`ifdef TOY_IMEM_RANGE_CHK_EN
      exp = 32'h5A5A_0FFF;
      n_chk++; if (ack_err !== 1'b0) $display("FAIL rng_in_err got=%0b exp=0", ack_err); else n_pass++;
`else
      exp = 32'h1234_5678;
`endif
      n_chk++; if (ack_vld !== 1'b1 || ack_data !== exp)
         $display("FAIL rng_last_word vld=%0b data=%h exp vld=1 data=%h", ack_vld, ack_data, exp); else n_pass++;
      cyc(); #3;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_read_first();
      test_range();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/toy_imem_responder.md
Name: toy_imem_responder

Overview:
- Instruction-memory responder: the slave end of the fetch request/ack interface.
- Accepts word fetch requests (addr/vld/rdy) and returns read data in request order through a valid/ready ack channel after a fixed pipelined read latency.
- Contains the instruction array, a program-load write port, and a flush that discards stale responses on a PC redirect.
- Sits between the fetch stage and the instruction SRAM/loader.

Parameters:
ADDR_WIDTH, 32, request/write address width
INST_WIDTH, 32, data word width
BASE_ADDR, 32'h8000_0000, byte address of array word 0
MEM_WORDS, 16384, array depth in words (power of 2)
RD_LAT, 2, read pipeline latency in cycles, legal 1..4
RSP_DEPTH, 4, max outstanding responses (in-flight plus buffered), must be >= RD_LAT

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_vld  in  1  fetch request valid
req_rdy  out  1  request accepted when req_vld && req_rdy
req_addr  in  ADDR_WIDTH  byte address; bits[1:0] ignored
ack_vld  out  1  response valid
ack_rdy  in  1  response consumed when ack_vld && ack_rdy
ack_data  out  INST_WIDTH  read word
flush  in  1  discard all in-flight and buffered responses
wr_en  in  1  loader write strobe
wr_addr  in  ADDR_WIDTH  loader byte address
wr_data  in  INST_WIDTH  loader data
wr_strb  in  INST_WIDTH/8  byte enables
ack_err  out  1  present only with TOY_IMEM_RANGE_CHK_EN

Behaviour:
- Reset: ack_vld=0, ack_data=0, ack_err=0, outstanding count=0, pipeline valids=0, response FIFO empty; req_rdy=1 one cycle after reset release. Array contents are not reset.
- Index: (req_addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits. The same mapping applies to wr_addr.
- Credit: outstanding register = accepted requests minus popped responses.
  - req_rdy = (outstanding < RSP_DEPTH) || flush.
  - The decrement from a pop becomes visible in req_rdy the next cycle. req_rdy has no combinational path from ack_rdy.
- Latency: a request accepted in cycle T gives ack_vld=1 in cycle T+RD_LAT at the earliest, with ack_rdy held high.
  - Back-to-back accepts stream one response per cycle.
  - Responses return strictly in request order.
- Response FIFO: RSP_DEPTH entries, fed by the last read pipeline stage.
  - Overflow is impossible by credit.
  - ack_vld = FIFO not empty; ack_data is the FIFO head.
  - ack_data holds stable while ack_vld && !ack_rdy.
  - Simultaneous push and pop is allowed at any occupancy.
- Flush (cycle T):
  - ack_vld is forced 0 during cycle T and no pop occurs.
  - All pipeline valids and the FIFO are cleared at the T edge.
  - outstanding becomes 1 if a request is accepted in T, else 0.
  - A request accepted in T is the redirect target: it is kept and its response appears at T+RD_LAT.
- Write port: byte-masked write at the clk edge. A read and a write to the same word in the same cycle return the old data (read-first). Writes are never blocked and ignore flush.
- Simultaneous accept, pop and flush: flush wins over pop; the accept is honoured.
- Reset asserted mid-operation: all in-flight responses are dropped immediately (async); array contents are retained.

Optional Feature:
Macro TOY_IMEM_RANGE_CHK_EN.
- Defined:
  - A request whose address is outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) returns ack_data=0 and ack_err=1 in its response slot.
  - Latency and ordering are unchanged.
  - Out-of-range writes are dropped.
  - ack_err is 0 for in-range responses and 0 while ack_vld=0.
- Undefined: the ack_err port is absent and out-of-range addresses wrap modulo MEM_WORDS for reads and writes.

Test Plan:
- Write 32'h0000_0013 to 8000_0000 and 32'h0010_0093 to 8000_0004. Request 8000_0000 at T (RD_LAT=2, ack_rdy=1) -> ack_vld at T+2 with data 0000_0013; request 8000_0004 at T+1 -> data 0010_0093 at T+3.
- Stream 8 consecutive addresses 8000_0000..8000_001C with ack_rdy=1 -> req_rdy stays 1 and 8 acks arrive on consecutive cycles in address order.
- Hold ack_rdy=0 and drive req_vld=1 (RSP_DEPTH=4) -> exactly 4 accepts, then req_rdy=0 and ack_data stable. One pop -> req_rdy=1 the following cycle, then exactly one more accept.
- Three requests in flight, then flush together with a request to 8000_0100 -> ack_vld=0 during the flush cycle and only the 8000_0100 word is returned, at flush+RD_LAT.
- In the same cycle, write 32'hDEAD_BEEF with strb 4'b0011 to 8000_0008 (old value 1111_2222) and read 8000_0008 -> read returns 1111_2222; a later read returns 1111_BEEF.
- With TOY_IMEM_RANGE_CHK_EN, request 7FFF_FFFC -> ack_data=0 and ack_err=1. Without the macro, the same request returns word MEM_WORDS-1.
